spi_rx_frame_buffer: RTL
========================

Name: spi_rx_frame_buffer

Overview:
- Sits directly downstream of the SPI transfer engine.
- Consumes the engine's received byte and its transfer-complete level (`ready`), and returns the `received` acknowledge that moves the engine from its transfer-done state back to ready.
- Assembles 8-bit or 16-bit frames (two bytes, MSB first) and queues them in a FIFO for a consumer (LED driver or CPU side).

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTR_W, 3, pointer width; equals log2(DEPTH).
- ACK_CYCLES, 2, width in clk cycles of the `received` pulse; at least 1.
- HALF_TIMEOUT, 1024, cycles allowed between the high and low byte of a 16-bit frame (used only by the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- xfer_done  in  1  engine transfer-complete level; stays high until `received`
- rx_byte  in  8  engine receive shift-register contents; valid while xfer_done is high
- len16  in  1  frame length: 1 = two bytes per frame, 0 = one byte
- received  out  1  acknowledge pulse to the engine
- rd_data  out  16  FIFO head; 8-bit frames are zero-extended in [15:8]
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer pop; effective only when rd_valid is high
- fill  out  PTR_W+1  current entry count, 0..DEPTH
- half_pend  out  1  high byte of a 16-bit frame is held, waiting for the low byte
- ovf  out  1  sticky: a frame was dropped because the FIFO was full
- clr_err  in  1  clears ovf (and frag_err when the optional feature is enabled)

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, pointers 0, fill 0, rd_valid 0, rd_data 0, received 0, half_pend 0, ovf 0, held high byte 0. A reset mid-handshake abandons the handshake; a partial frame is lost.
- xfer_done is treated as already synchronous to clk. Capture is triggered by its rising edge (registered previous value); a level that stays high never triggers a second capture.
- IDLE: on the rising edge of xfer_done, go to CAPTURE.
- CAPTURE (1 cycle): sample rx_byte.
  - len16 = 1 and half_pend = 0: store as high byte, set half_pend, no push.
  - len16 = 1 and half_pend = 1: push {high, rx_byte}, clear half_pend.
  - len16 = 0: push {8'h00, rx_byte}, clear half_pend; any held high byte is discarded.
  - Always go to ACK.
- ACK: received = 1 for exactly ACK_CYCLES cycles, then go to WAIT_LOW.
- WAIT_LOW: return to IDLE when xfer_done = 0. If xfer_done is already low, return on the next cycle.
- Push/pop rules:
  - A push is accepted if fill < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the frame is dropped and ovf is set the following cycle. received is still issued, so the engine never stalls.
  - Pop occurs when rd_valid and rd_ready are both high; the read pointer advances.
  - rd_data is combinational from the head entry, so the next entry is visible the cycle after a pop.
  - Push and pop in the same cycle: fill unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: xfer_done rising edge to rd_valid high is 3 clk cycles (edge register, CAPTURE, write).
- clr_err: clears the sticky errors next cycle. If a new error occurs in the same cycle, set wins.
- A len16 change while half_pend = 1 takes effect at the next CAPTURE, per the CAPTURE rules above.

Optional Feature:
- Macro: RX_HALF_TIMEOUT_EN
- Defined:
  - A counter runs while half_pend = 1.
  - On reaching HALF_TIMEOUT cycles: the held byte is discarded, half_pend clears, and sticky output frag_err (1 bit, reset 0) is set.
  - The counter restarts on every new high-byte capture.
- Not defined: no counter, no frag_err port; half_pend persists indefinitely.

Test Plan:
- Reset, len16 = 0, xfer_done rises with rx_byte 8'hA5 → received high for 2 cycles, rd_data 16'h00A5, rd_valid 3 cycles after the edge, fill 1.
- len16 = 1, two transfers with bytes 8'h12 then 8'h34 → half_pend 1 after the first; one entry 16'h1234 after the second; fill 1.
- 9 frames with rd_ready = 0 and DEPTH 8 → fill 8, ovf 1, the ninth frame is dropped but still acknowledged. Drain → values 1..8 in order. clr_err → ovf 0.
- FIFO full, frame arrives in the same cycle as a pop → push accepted, fill stays 8, ovf stays 0.
- xfer_done held high for 50 cycles → exactly one capture and one received pulse.
- rst low mid-ACK → received 0, fill 0, half_pend 0 immediately.
- With RX_HALF_TIMEOUT_EN: high byte then 1024 idle cycles → half_pend 0, frag_err 1.

Source files
------------

// File: rtl/spi_rx_frame_buffer.sv
// Receive-side frame assembler and FIFO behind the SPI transfer engine.
// Optional macro RX_HALF_TIMEOUT_EN adds a half-frame timeout with a sticky frag_err output.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a registered rising edge of xfer_done
// CAPTURE  | sample rx_byte, hold the high byte or push a frame
// ACK      | drive received for ACK_CYCLES cycles
// WAIT_LOW | wait for the engine to drop xfer_done
module spi_rx_frame_buffer #(
  parameter int DEPTH        = 8,
  parameter int PTR_W        = 3,
  parameter int ACK_CYCLES   = 2,
  parameter int HALF_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_done,
  input  logic [7:0]       rx_byte,
  input  logic             len16,
  output logic             received,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PTR_W:0]   fill,
  output logic             half_pend,
  output logic             ovf,
  input  logic             clr_err
`ifdef RX_HALF_TIMEOUT_EN
  ,
  output logic             frag_err
`endif
);

  localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W + 1)'(DEPTH);

  if (DEPTH != (1 << PTR_W) || DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2 and equal 2**PTR_W");
  end
  if (ACK_CYCLES < 1 || HALF_TIMEOUT < 1) begin : g_bad_cycles
    $error("ACK_CYCLES and HALF_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_LOW} state_t;

  state_t           state, state_nxt;
  logic             xfer_q, rise_q;
  logic [ACK_W-1:0] ack_cnt;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic [7:0]       hi_byte;
  logic             pend;
  logic             ovf_q;
  logic             push, push_ok, pop, drop, take_high, timeout;
  logic [15:0]      frame;

  // Edge register: the rise is registered so capture lands two cycles after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      xfer_q <= xfer_done;
      rise_q <= xfer_done & ~xfer_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CAPTURE)
        ack_cnt <= ACK_LOAD;
      else if (state == ACK && ack_cnt != '0)
        ack_cnt <= ack_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (rise_q) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = ACK;
      ACK:      if (ack_cnt == '0) state_nxt = WAIT_LOW;
      WAIT_LOW: if (!xfer_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign received  = (state == ACK);
  assign take_high = (state == CAPTURE) && len16 && !pend;
  assign push      = (state == CAPTURE) && (!len16 || pend);
  assign pop       = rd_valid && rd_ready;
  assign push_ok   = push && ((count != DEPTH_V) || pop);
  assign drop      = push && !push_ok;
  assign frame     = len16 ? {hi_byte, rx_byte} : {8'h00, rx_byte};

  // Storage needs no reset: rd_data is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= frame;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rptr] : 16'h0000;
  assign fill     = count;

`ifdef RX_HALF_TIMEOUT_EN
  localparam int TO_W = (HALF_TIMEOUT > 1) ? $clog2(HALF_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(HALF_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            frag_q;

  // A low-byte capture in the expiry cycle still completes the frame.
  assign timeout = pend && (to_cnt == '0) && (state != CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      frag_q <= 1'b0;
    end else begin
      if (take_high)
        to_cnt <= TO_LOAD;
      else if (pend && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
      if (timeout)
        frag_q <= 1'b1;
      else if (clr_err)
        frag_q <= 1'b0;
    end
  end

  assign frag_err = frag_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_byte <= 8'h00;
      pend    <= 1'b0;
    end else if (take_high) begin
      hi_byte <= rx_byte;
      pend    <= 1'b1;
    end else if (push || timeout) begin
      hi_byte <= 8'h00;
      pend    <= 1'b0;
    end
  end

  assign half_pend = pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (clr_err)
      ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;

endmodule
